// File: rtl/mvm_ctrl.sv
// Load/start/wait/drain controller that feeds weights and x operands to an MVM
// and streams back its result. Optional timeout watchdog: MVMCTRL_TIMEOUT_EN.
module mvm_ctrl #(
  parameter int NUM_BIT    = 16,
  parameter int NUM_VECTOR = 4,
  parameter int DIM        = 4
) (
  input  logic                              i_clk_mvmCtrl,
  input  logic                              i_rst_n_mvmCtrl,
  input  logic                              i_in_valid,
  output logic                              o_in_ready,
  input  logic [NUM_BIT-1:0]                i_in_data,
  output logic                              o_start_topMvm,
  output logic [NUM_VECTOR*DIM*NUM_BIT-1:0] o_x_vectors,
  output logic [NUM_VECTOR*NUM_BIT-1:0]     o_wts,
  input  logic [DIM*NUM_BIT-1:0]            i_y_vector,
  input  logic                              i_isAcc,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [NUM_BIT-1:0]                o_out_data,
  output logic                              o_busy,
  output logic [23:0]                       o_cycles,
  output logic                              o_err
);

  localparam int LD_N = NUM_VECTOR * (DIM + 1);
  localparam int LD_W = (LD_N > 1) ? $clog2(LD_N) : 1;
  localparam int K_W  = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DRAIN
  } state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic [LD_W-1:0]                   r_ld_idx;
  logic [K_W-1:0]                    r_k;
  logic [NUM_VECTOR*NUM_BIT-1:0]     r_wts;
  logic [NUM_VECTOR*DIM*NUM_BIT-1:0] r_x;
  logic [DIM*NUM_BIT-1:0]            r_ybuf;
  logic [23:0]                       r_cycles;

  logic w_accept;
  logic w_ld_last;
  logic w_k_last;
  logic w_in_wait;
  logic w_timeout;

  assign w_accept  = (r_state == S_LOAD) && i_in_valid;
  assign w_ld_last = (r_ld_idx == LD_W'(LD_N - 1));
  assign w_k_last  = (r_k == K_W'(DIM - 1));
  assign w_in_wait = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);

`ifdef MVMCTRL_TIMEOUT_EN
  logic r_err;

  // Fires on the cycle whose increment brings the count to 16'hFFFF.
  assign w_timeout = w_in_wait && (r_cycles == 24'h00FFFE);
  assign o_err     = r_err;

  always_ff @(posedge i_clk_mvmCtrl or negedge i_rst_n_mvmCtrl) begin
    if (!i_rst_n_mvmCtrl) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk_mvmCtrl or negedge i_rst_n_mvmCtrl) begin
    if (!i_rst_n_mvmCtrl) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_next         = r_state;
    o_in_ready     = 1'b0;
    o_start_topMvm = 1'b0;
    o_out_valid    = 1'b0;
    o_busy         = 1'b1;
    case (r_state)
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (w_accept && w_ld_last) w_next = S_START;
      end
      S_START: begin
        o_start_topMvm = 1'b1;
        w_next         = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (w_timeout)    w_next = S_LOAD;
        else if (i_isAcc) w_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (w_timeout)     w_next = S_LOAD;
        else if (!i_isAcc) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_out_valid = 1'b1;
        if (i_out_ready && w_k_last) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // NOTE: the operand and result buffers are reset along with the control
  // state so an aborted job never leaves stale operands on the MVM inputs.
  always_ff @(posedge i_clk_mvmCtrl or negedge i_rst_n_mvmCtrl) begin
    if (!i_rst_n_mvmCtrl) begin
      r_ld_idx <= '0;
      r_k      <= '0;
      r_wts    <= '0;
      r_x      <= '0;
      r_ybuf   <= '0;
      r_cycles <= '0;
    end else begin
      if (w_accept) begin
        if (int'(r_ld_idx) < NUM_VECTOR) begin
          r_wts[int'(r_ld_idx)*NUM_BIT +: NUM_BIT] <= i_in_data;
        end else begin
          // x words arrive j-outer, i-inner, which is exactly the flat order.
          r_x[(int'(r_ld_idx) - NUM_VECTOR)*NUM_BIT +: NUM_BIT] <= i_in_data;
        end
        r_ld_idx <= w_ld_last ? '0 : r_ld_idx + 1'b1;
      end

      if (r_state == S_START) begin
        r_cycles <= '0;
      end else if (w_in_wait && (r_cycles != 24'hFFFFFF)) begin
        r_cycles <= r_cycles + 24'd1;
      end

      if ((r_state == S_WAIT_LO) && (w_next == S_DRAIN)) begin
        r_ybuf <= i_y_vector;
      end

      if ((r_state == S_DRAIN) && i_out_ready) begin
        r_k <= w_k_last ? '0 : r_k + 1'b1;
      end
    end
  end

  assign o_wts       = r_wts;
  assign o_x_vectors = r_x;
  assign o_cycles    = r_cycles;
  assign o_out_data  = r_ybuf[int'(r_k)*NUM_BIT +: NUM_BIT];

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed self-checking bench for mvm_ctrl: standard jobs, stalled drain,
// stray load words, mid-job reset and (with MVMCTRL_TIMEOUT_EN) the watchdog.
module tb_mvm_ctrl;

  logic          clk;
  logic          rst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [15:0]   i_in_data;
  logic          o_start_topMvm;
  logic [255:0]  o_x_vectors;
  logic [63:0]   o_wts;
  logic [63:0]   i_y_vector;
  logic          i_isAcc;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [15:0]   o_out_data;
  logic          o_busy;
  logic [23:0]   o_cycles;
  logic          o_err;

  int checks   = 0;
  int failures = 0;

  mvm_ctrl #(.NUM_BIT(16), .NUM_VECTOR(4), .DIM(4)) dut (
    .i_clk_mvmCtrl   (clk),
    .i_rst_n_mvmCtrl (rst_n),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .i_in_data       (i_in_data),
    .o_start_topMvm  (o_start_topMvm),
    .o_x_vectors     (o_x_vectors),
    .o_wts           (o_wts),
    .i_y_vector      (i_y_vector),
    .i_isAcc         (i_isAcc),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_busy          (o_busy),
    .o_cycles        (o_cycles),
    .o_err           (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams 20 words: w[j]=64+off+j, then x[j][i]=64+off+i+j.
  task automatic load_job(input int off);
    for (int n = 0; n < 20; n++) begin
      i_in_valid = 1'b1;
      if (n < 4) i_in_data = 16'(64 + off + n);
      else       i_in_data = 16'(64 + off + (n - 4) % 4 + (n - 4) / 4);
      step();
    end
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_in_ready"}, 64'(o_in_ready), 64'd1);
    check({pfx, "_start"},    64'(o_start_topMvm), 64'd0);
    check({pfx, "_valid"},    64'(o_out_valid), 64'd0);
    check({pfx, "_busy"},     64'(o_busy), 64'd0);
    check({pfx, "_err"},      64'(o_err), 64'd0);
    check({pfx, "_cycles"},   64'(o_cycles), 64'd0);
    check({pfx, "_out_data"}, 64'(o_out_data), 64'd0);
    check({pfx, "_wts"},      o_wts, 64'd0);
    check({pfx, "_x_zero"},   64'(o_x_vectors == '0), 64'd1);
  endtask

  task automatic run_job(input string nm, input int off, input logic [63:0] exp_wts,
                         input int acc_len, input logic [63:0] y, input bit toggle);
    int k;
    load_job(off);
    check({nm, "_start_pulse"}, 64'(o_start_topMvm), 64'd1);
    check({nm, "_ready_drop"},  64'(o_in_ready), 64'd0);
    check({nm, "_wts"},         o_wts, exp_wts);
    check({nm, "_x00"},         64'(o_x_vectors[15:0]), 64'(64 + off));
    check({nm, "_x33"},         64'(o_x_vectors[255:240]), 64'(70 + off));
    i_in_valid = 1'b0;
    step();
    check({nm, "_start_once"},  64'(o_start_topMvm), 64'd0);
    check({nm, "_busy_wait"},   64'(o_busy), 64'd1);
    // Stray load word while waiting for the MVM.
    i_in_valid = 1'b1;
    i_in_data  = 16'hDEAD;
    i_isAcc    = 1'b1;
    i_y_vector = y;
    step();
    i_in_valid = 1'b0;
    check({nm, "_no_ready_wait"}, 64'(o_in_ready), 64'd0);
    repeat (acc_len - 1) step();
    i_isAcc = 1'b0;
    step();
    check({nm, "_drain_valid"}, 64'(o_out_valid), 64'd1);
    check({nm, "_cycles"},      64'(o_cycles), 64'(acc_len + 1));
    check({nm, "_wts_hold"},    o_wts, exp_wts);
    k = 0;
    i_in_valid = 1'b1;
    i_in_data  = 16'hBEEF;
    for (int s = 0; s < 16 && k < 4; s++) begin
      i_out_ready = toggle ? s[0] : 1'b1;
      check({nm, "_out_word"},  64'(o_out_data), 64'(y[k*16 +: 16]));
      check({nm, "_out_valid"}, 64'(o_out_valid), 64'd1);
      step();
      i_in_valid = 1'b0;
      if (i_out_ready) k++;
    end
    i_out_ready = 1'b0;
    check({nm, "_done_valid"}, 64'(o_out_valid), 64'd0);
    check({nm, "_done_busy"},  64'(o_busy), 64'd0);
    check({nm, "_done_ready"}, 64'(o_in_ready), 64'd1);
    check({nm, "_wts_final"},  o_wts, exp_wts);
    check({nm, "_x33_final"},  64'(o_x_vectors[255:240]), 64'(70 + off));
  endtask

  initial begin
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_y_vector  = '0;
    i_isAcc     = 1'b0;
    i_out_ready = 1'b0;
    #12;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_job("std", 0, 64'h0043_0042_0041_0040, 10, 64'h0190_012C_00C8_0064, 1'b0);
    run_job("tog", 16, 64'h0053_0052_0051_0050, 3, 64'h0444_0333_0222_0111, 1'b1);

    // Abort in WAIT_LO with an asynchronous reset.
    load_job(0);
    i_in_valid = 1'b0;
    step();
    i_isAcc = 1'b1;
    step();
    step();
    check("pre_abort_busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    reset_checks("abort");
    i_isAcc = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_job("post", 0, 64'h0043_0042_0041_0040, 10, 64'h0190_012C_00C8_0064, 1'b0);

`ifdef MVMCTRL_TIMEOUT_EN
    begin
      bit seen_valid;
      seen_valid = 1'b0;
      load_job(0);
      i_in_valid = 1'b0;
      step();
      i_isAcc = 1'b1;
      for (int c = 0; c < 70000 && !o_err; c++) begin
        step();
        if (o_out_valid) seen_valid = 1'b1;
      end
      check("to_err",    64'(o_err), 64'd1);
      check("to_cycles", 64'(o_cycles), 64'h0000_FFFF);
      check("to_busy",   64'(o_busy), 64'd0);
      check("to_nodrain", 64'(seen_valid), 64'd0);
      i_isAcc = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
